// File: rtl/mips32_pkg.sv
// Shared constants and helpers for the MIPS32 register file / scoreboard.
package mips32_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 32;
    // Pending counters hold 0..7, so three bits cover every legal MAXPEND.
    localparam int CNT_W     = 3;

    // Address width for a register file of n entries (never less than 1 bit).
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mips32_sb_counter.sv
// Per-register saturating up/down pending-claim counter.
module mips32_sb_counter
    import mips32_pkg::*;
#(
    parameter int MAXPEND = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Count up on a claim, down on a writeback; simultaneous events cancel
    // and the value clamps at both ends instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && !dec && count_reg != CNT_W'(MAXPEND)) begin
            count_reg <= count_reg + 1'b1;
        end else if (dec && !inc && count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mips32_regfile_sb.sv
// MIPS32 register file with combinational write-through reads and a
// per-register pending-claim scoreboard for the issue stage.
module mips32_regfile_sb
    import mips32_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREGS   = DEF_NREGS,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int MAXPEND = 3,
    localparam int AW     = addr_width(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NRD*AW-1:0]  rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]     rd_busy,
    input  logic               claim_valid,
    input  logic [AW-1:0]      claim_addr,
    output logic               claim_ok,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    output logic               err
);

    logic [WIDTH-1:0] mem_reg [NREGS];
    logic [CNT_W-1:0] cnt [NREGS];
    logic             run_reg;
    logic             err_reg;
    logic             wr_eff;
    logic             claim_eff;
    logic             wr_hits_claim;

    // Operations are held off until one full edge has passed after reset
    // release, so a claim/write sitting on the bus at deassertion is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_reg <= 1'b0;
        else        run_reg <= 1'b1;
    end

    // Effective strobes: gated by the run flag and by the hardwired r0.
    assign wr_eff = run_reg && wr_en && !(ZERO_R0 != 0 && wr_addr == '0);
    assign wr_hits_claim = wr_eff && (wr_addr == claim_addr);
    assign claim_ok = (cnt[claim_addr] != CNT_W'(MAXPEND)) || wr_hits_claim;
    assign claim_eff = run_reg && claim_valid && claim_ok
                       && !(ZERO_R0 != 0 && claim_addr == '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic hit_wr;
            logic hit_claim;

            assign hit_wr    = wr_eff && (wr_addr == AW'(gi));
            assign hit_claim = claim_eff && (claim_addr == AW'(gi));

            // Storage word: writeback lands one edge after the strobe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      mem_reg[gi] <= '0;
                else if (hit_wr) mem_reg[gi] <= wr_data;
            end

            mips32_sb_counter #(.MAXPEND(MAXPEND)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (hit_claim),
                .dec   (hit_wr),
                .count (cnt[gi])
            );
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          is_zero;
            logic          bypass;

            assign addr    = rd_addr[gi*AW +: AW];
            assign is_zero = (ZERO_R0 != 0) && (addr == '0);
            assign bypass  = wr_eff && (wr_addr == addr);

            // Read mux with writeback forwarding; the last outstanding claim
            // retiring this cycle is not busy because its data is forwarded.
            always_comb begin
                rd_data[gi*WIDTH +: WIDTH] = mem_reg[addr];
                rd_busy[gi] = (cnt[addr] != '0)
                              && !((cnt[addr] == CNT_W'(1)) && bypass);
                if (bypass) rd_data[gi*WIDTH +: WIDTH] = wr_data;
                if (is_zero) begin
                    rd_data[gi*WIDTH +: WIDTH] = '0;
                    rd_busy[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Sticky error: a writeback with no outstanding claim for its register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         err_reg <= 1'b0;
        else if (wr_eff && cnt[wr_addr] == '0) err_reg <= 1'b1;
    end

    assign err = err_reg;

endmodule

// File: tb/tb_mips32_regfile_sb.sv
// Directed bench for mips32_regfile_sb (default parameters, two read ports).
module tb_mips32_regfile_sb;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2*AW-1:0] rd_addr;
    logic [2*W-1:0]  rd_data;
    logic [1:0]    rd_busy;
    logic          claim_valid;
    logic [AW-1:0] claim_addr;
    logic          claim_ok;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    mips32_regfile_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .claim_ok    (claim_ok),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        claim_valid = 1'b0;
        wr_en       = 1'b0;
    endtask

    function automatic logic [31:0] rdat(input int p);
        return rd_data[p*W +: W];
    endfunction

    // Sweep every register through both ports and expect zero / not busy.
    task automatic check_all_clear(input string tag);
        for (int r = 0; r < 32; r += 2) begin
            set_rd(AW'(r), AW'(r + 1));
            #1;
            check($sformatf("%s data r%0d", tag, r), rdat(0), 32'h0);
            check($sformatf("%s data r%0d", tag, r + 1), rdat(1), 32'h0);
            check($sformatf("%s busy r%0d/r%0d", tag, r, r + 1), {30'b0, rd_busy}, 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        claim_addr = '0;
        wr_addr    = '0;
        wr_data    = '0;
        set_rd(0, 0);
        step();
        step();
        check("in-reset err", {31'b0, err}, 32'h0);
        check("in-reset claim_ok", {31'b0, claim_ok}, 32'h1);

        // Release reset with a claim and write already presented: both dropped.
        rst_n = 1'b1;
        claim_valid = 1'b1; claim_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hDEAD;
        step();
        idle();
        set_rd(9, 10);
        #1;
        check("deassert claim ignored", {31'b0, rd_busy[0]}, 32'h0);
        check("deassert write ignored", rdat(1), 32'h0);
        check("deassert err", {31'b0, err}, 32'h0);

        check_all_clear("post-reset");
        check("post-reset claim_ok", {31'b0, claim_ok}, 32'h1);
        check("post-reset err", {31'b0, err}, 32'h0);

        // Claim r3, see it busy, retire it with bypass.
        claim_valid = 1'b1; claim_addr = 5'd3;
        #1 check("r3 claim_ok", {31'b0, claim_ok}, 32'h1);
        step();
        idle();
        set_rd(3, 0);
        #1 check("r3 busy after claim", {31'b0, rd_busy[0]}, 32'h1);
        step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234;
        #1;
        check("r3 bypass data", rdat(0), 32'h1234);
        check("r3 bypass busy", {31'b0, rd_busy[0]}, 32'h0);
        step();
        idle();
        #1;
        check("r3 stored data", rdat(0), 32'h1234);
        check("r3 stored busy", {31'b0, rd_busy[0]}, 32'h0);
        check("r3 err", {31'b0, err}, 32'h0);

        // Saturate r2 at three claims.
        for (int k = 0; k < 3; k++) begin
            claim_valid = 1'b1; claim_addr = 5'd2;
            #1 check($sformatf("r2 claim %0d ok", k + 1), {31'b0, claim_ok}, 32'h1);
            step();
        end
        set_rd(0, 2);
        #1 check("r2 full claim_ok", {31'b0, claim_ok}, 32'h0);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hAA;
        #1 check("r2 claim+wb ok", {31'b0, claim_ok}, 32'h1);
        step();
        wr_en = 1'b0;
        #1;
        check("r2 still full", {31'b0, claim_ok}, 32'h0);
        check("r2 busy", {31'b0, rd_busy[1]}, 32'h1);
        step();          // rejected claim held across an edge
        idle();
        // Drain: exactly three writebacks must empty the counter.
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hB0 + k;
            #1 check($sformatf("r2 drain %0d busy", k + 1), {31'b0, rd_busy[1]},
                     (k == 2) ? 32'h0 : 32'h1);
            step();
        end
        idle();
        #1;
        check("r2 drained busy", {31'b0, rd_busy[1]}, 32'h0);
        check("r2 data", rdat(1), 32'hB2);
        check("r2 err", {31'b0, err}, 32'h0);

        // Register zero ignores writes, claims and bypass.
        set_rd(0, 0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF;
        claim_valid = 1'b1; claim_addr = 5'd0;
        #1;
        check("r0 bypass data", rdat(0), 32'h0);
        check("r0 bypass busy", {31'b0, rd_busy[0]}, 32'h0);
        step();
        idle();
        #1;
        check("r0 data", rdat(0), 32'h0);
        check("r0 busy", {31'b0, rd_busy[0]}, 32'h0);
        check("r0 err", {31'b0, err}, 32'h0);
        check("r0 claim_ok", {31'b0, claim_ok}, 32'h1);

        // Unclaimed writeback to r5: data lands, err latches, counter stays 0.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5555;
        step();
        idle();
        set_rd(5, 7);
        #1;
        check("r5 err set", {31'b0, err}, 32'h1);
        check("r5 data", rdat(0), 32'h5555);
        check("r5 busy", {31'b0, rd_busy[0]}, 32'h0);
        claim_valid = 1'b1; claim_addr = 5'd5;
        step();
        claim_addr = 5'd7;
        #1 check("r5 one claim busy", {31'b0, rd_busy[0]}, 32'h1);
        step();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h6666;
        step();
        idle();
        #1;
        check("r5 retired busy", {31'b0, rd_busy[0]}, 32'h0);
        check("r7 busy", {31'b0, rd_busy[1]}, 32'h1);
        check("err sticky", {31'b0, err}, 32'h1);

        // Asynchronous reset in mid-stream.
        claim_valid = 1'b1; claim_addr = 5'd7;
        #2 rst_n = 1'b0;
        #1;
        check("async rst err", {31'b0, err}, 32'h0);
        check("async rst r7 busy", {31'b0, rd_busy[1]}, 32'h0);
        check("async rst r5 data", rdat(0), 32'h0);
        step();
        idle();
        rst_n = 1'b1;
        step();
        check_all_clear("after re-reset");
        check("re-reset err", {31'b0, err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
